// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - state type, sr_mode encodings and helpers for shift_sequencer
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_SHR  = 2'b11;

    function automatic logic [1:0] shift_mode(input logic dir);
        return dir ? MODE_SHR : MODE_SHL;
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - command, shift-register and response signals of shift_sequencer
// slave is the sequencer's view; master is the parent's view (driver, shift register, sink).
interface shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;

    logic [1:0]       sr_mode;
    logic [WIDTH-1:0] sr_data;
    logic [WIDTH-1:0] sr_q;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport slave (
        input  cmd_valid, cmd_dir, cmd_count, cmd_data, sr_q, rsp_ready,
        output cmd_ready, sr_mode, sr_data, rsp_valid, rsp_data
    );

    modport master (
        output cmd_valid, cmd_dir, cmd_count, cmd_data, sr_q, rsp_ready,
        input  cmd_ready, sr_mode, sr_data, rsp_valid, rsp_data
    );

endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - sequences load and N shifts of an external shift register per command
// Define SHIFT_SEQ_PIPE_EN to accept the next command on the response handshake edge.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    shift_sequencer_if.slave bus
);

    state_t           r_state;
    state_t           w_next;
    logic             r_dir;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_remaining;
    logic [WIDTH-1:0] r_data;

    logic             w_cmd_ready;
    logic             w_accept;
    logic             w_rsp_valid;
    logic [1:0]       w_mode;

    assign w_accept = bus.cmd_valid & w_cmd_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_dir       <= 1'b0;
            r_count     <= '0;
            r_remaining <= '0;
            r_data      <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_dir   <= bus.cmd_dir;
                r_count <= bus.cmd_count;
                r_data  <= bus.cmd_data;
            end
            if (r_state == LOAD) begin
                r_remaining <= r_count;
            end else if (r_state == SHIFT) begin
                r_remaining <= r_remaining - CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cmd_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_mode      = MODE_HOLD;
        case (r_state)
            IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_mode = MODE_LOAD;
                w_next = (r_count == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                w_mode = shift_mode(r_dir);
                if (r_remaining == CNT_W'(1)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_rsp_valid = 1'b1;
`ifdef SHIFT_SEQ_PIPE_EN
                // A command arriving with the response handshake skips IDLE entirely.
                w_cmd_ready = bus.rsp_ready;
                if (bus.rsp_ready) begin
                    w_next = bus.cmd_valid ? LOAD : IDLE;
                end
`else
                if (bus.rsp_ready) begin
                    w_next = IDLE;
                end
`endif
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Reset is synchronous, so outputs are forced to idle values while reset_n is low.
    assign bus.cmd_ready = reset_n ? w_cmd_ready : 1'b1;
    assign bus.rsp_valid = reset_n & w_rsp_valid;
    assign bus.sr_mode   = reset_n ? w_mode : MODE_HOLD;
    assign bus.sr_data   = reset_n ? r_data : '0;
    assign bus.rsp_data  = bus.sr_q;

endmodule
